shared_bus_arbiter: RTL and testbench
=====================================

// Module: shared_bus_arbiter
// PURPOSE
//   Round-robin arbiter for a shared 4-state logic bus. Grants one of N requesters, muxes its data onto bus_data.
//   Drives 'z onto the bus when no requester is granted.
//   Inserts one dead cycle between owners so two drivers never overlap.
//   Flags X/Z on request lines or on driven bus data through a sticky error bit.
//   Sits between requester agents and a shared logic-typed data/enable bus.
// PARAMETERS
//   N         4   number of requesters (>=2)
//   W         4   bus data width in bits
//   HOLD_MAX  8   max consecutive grant cycles before forced hand-off when others wait (>=1)
// PORTS
//   clk        in   1               rising-edge clock
//   rst_n      in   1               asynchronous active-low reset
//   req        in   N               request per requester, level-held until done
//   req_data   in   N*W             requester i data at [i*W +: W]
//   x_err_clr  in   1               clears x_err (synchronous)
//   gnt        out  N               one-hot grant, registered
//   gnt_id     out  $clog2(N)       index of granted requester (valid when bus_en=1)
//   bus_en     out  1               1 while a requester owns the bus
//   bus_data   out  W               granted data when bus_en=1, else all 'z
//   x_err      out  1               sticky unknown-value error
// BEHAVIOUR
//   Reset (async, immediate on rst_n=0, also mid-grant):
//     gnt=0, gnt_id=0, bus_en=0, bus_data='z, x_err=0, state=IDLE, rr ptr=0, hold_cnt=0.
//   Clean request: creq[i] = req[i] if req[i] is 0/1; an X/Z req bit is treated as 0.
//   Round-robin pick: first i with creq[i]=1, searching from ptr upward, wrapping N-1 -> 0.
//   FSM
//     IDLE: any creq -> GRANT (gnt/gnt_id/bus_en registered). Latency is 1 clk from req to gnt.
//     GRANT: bus_en=1, bus_data=req_data[gnt_id] (comb from registered gnt_id).
//       hold_cnt increments each cycle and saturates at HOLD_MAX-1.
//       creq[gnt_id]=0 -> TURN.
//       hold_cnt==HOLD_MAX-1 and any other creq=1 -> TURN (preempt).
//       Sole requester keeps the grant indefinitely.
//     TURN: gnt=0, bus_en=0, bus_data='z for exactly 1 cycle. ptr <= (gnt_id+1) mod N.
//       Any creq (using the new ptr) -> GRANT; else -> IDLE.
//   hold_cnt clears on every entry to GRANT.
//   Preempted requester still holding req stays eligible and is served again in round-robin order.
//   x_err set next clk if $isunknown(req) or (bus_en && $isunknown(bus_data)).
//   x_err is sticky; x_err_clr clears it. Set wins over clear in the same cycle.
//   X-valued data passes unchanged onto the bus (no masking).
//   gnt is always one-hot or zero, never multi-hot.
// TESTING
//   1. rst_n=0 at t0, then released -> gnt=0, bus_en=0, bus_data=4'bzzzz, x_err=0.
//   2. req=4'b0100, req_data[2]=4'd3 -> next clk gnt=4'b0100, gnt_id=2, bus_data=3.
//      Drop req -> 1-clk 'z gap, then IDLE.
//   3. req=4'b1111 held, HOLD_MAX=8 -> grants 0,1,2,3,0.
//      Each owner holds 8 clks, separated by 1 'z cycle; ptr wraps 3->0.
//   4. req[1]=1'bx, req[3]=1 -> requester 3 granted, x_err=1 next clk.
//      x_err stays 1 until x_err_clr; with clr and a new X in the same clk, x_err stays 1.
//   5. Granted requester 0 with req_data[0]=4'bx01x -> bus_data=4'bx01x and x_err=1.
//   6. rst_n=0 mid-GRANT -> gnt=0, bus_en=0, bus_data='z immediately (before next clk edge).
//      After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter: round-robin owner selection for a shared 4-state bus.
// A registered one-hot grant selects one requester's data onto bus_data.
// The bus floats to 'z whenever nobody owns it. Every hand-off passes through
// one idle TURN cycle, so two owners never drive in back-to-back cycles.
// A sticky x_err flags unknown request bits or unknown data on a driven bus.
module shared_bus_arbiter #(
   parameter int N        = 4,
   parameter int W        = 4,
   parameter int HOLD_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       req_data,
   input  logic                 x_err_clr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 bus_en,
   output logic [W-1:0]         bus_data,
   output logic                 x_err
);

   localparam int IW = $clog2(N);
   localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] TURN  = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] ptr;
   logic [HW-1:0] hold_cnt;
   logic [N-1:0]  creq;
   logic [W-1:0]  data_arr [N];
   logic [W-1:0]  sel_data;
   logic [IW-1:0] nxt_id;
   logic [IW-1:0] base;
   logic [IW-1:0] idx;
   logic [IW-1:0] pick_id;
   logic          pick_vld;
   logic          others_req;
   logic          x_set;

   // Per-requester cleanup: only a solid 1 counts as a request; X/Z reads as idle.
   for (genvar i = 0; i < N; i++) begin : g_lane
      assign creq[i]     = (req[i] === 1'b1);
      assign data_arr[i] = req_data[i*W +: W];
   end

   assign sel_data   = data_arr[gnt_id];
   assign bus_data   = bus_en ? sel_data : {W{1'bz}};
   assign nxt_id     = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
   assign others_req = |(creq & ~gnt);
   assign x_set      = $isunknown(req) || (bus_en && $isunknown(sel_data));

   // Round-robin pick: nearest requester at or above the search base, with wrap.
   // During TURN the base is already the advanced pointer, so the next owner
   // is chosen in the same cycle that the pointer moves.
   always_comb begin
      base     = (state == TURN) ? nxt_id : ptr;
      pick_vld = 1'b0;
      pick_id  = '0;
      idx      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IW'((int'(base) + k) % N);
         if (creq[idx]) begin
            pick_vld = 1'b1;
            pick_id  = idx;
         end
      end
   end

   // Ownership FSM: IDLE -> GRANT -> TURN (dead cycle) -> GRANT/IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         bus_en   <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE, TURN: begin
               if (state == TURN) ptr <= nxt_id;
               if (pick_vld) begin
                  state    <= GRANT;
                  gnt      <= {{(N-1){1'b0}}, 1'b1} << pick_id;
                  gnt_id   <= pick_id;
                  bus_en   <= 1'b1;
                  hold_cnt <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            GRANT: begin
               hold_cnt <= (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
               // Release when the owner drops, or preempt a long holder if anyone waits.
               if (!creq[gnt_id] || (hold_cnt == HOLD_LAST && others_req)) begin
                  state  <= TURN;
                  gnt    <= '0;
                  bus_en <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               gnt    <= '0;
               bus_en <= 1'b0;
            end
         endcase
      end
   end

   // Sticky unknown-value flag; a new unknown beats a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         x_err <= 1'b0;
      else if (x_set)     x_err <= 1'b1;
      else if (x_err_clr) x_err <= 1'b0;
   end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter (N=4, W=4, HOLD_MAX=8).
// Inputs change 1 time unit after a rising edge and outputs are checked there.
// On a 2-state simulator, X/Z cannot be represented. The bench detects this at
// start-up. It then drives clean values where X would go, expects x_err=0, and
// skips the checks that compare bus_data against 'z or X patterns.
module tb_shared_bus_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic        x_err_clr;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        bus_en;
   logic [3:0]  bus_data;
   logic        x_err;

   int   total = 0;
   int   bad   = 0;
   logic probe;
   logic fs;

   shared_bus_arbiter #(.N(4), .W(4), .HOLD_MAX(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .x_err_clr(x_err_clr),
      .gnt(gnt), .gnt_id(gnt_id), .bus_en(bus_en), .bus_data(bus_data), .x_err(x_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'h0);
      chk({tag, "_en"}, 32'(bus_en), 32'h0);
      if (fs) chk({tag, "_z"}, 32'(bus_data), 32'(4'bzzzz));
   endtask

   initial begin
      probe = 1'bx;
      fs    = (probe === 1'bx);
      rst_n = 1'b0; req = '0; req_data = '0; x_err_clr = 1'b0;

      // 1: reset state
      #1;
      chk_idle("t1_rst");
      chk("t1_id", 32'(gnt_id), 32'h0);
      chk("t1_xerr", 32'(x_err), 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk_idle("t1_post");
      chk("t1_xerr_post", 32'(x_err), 32'h0);

      // 2: single requester 2, then drop -> dead cycle -> idle
      req_data = 16'h0300; req = 4'b0100;
      tick();
      chk("t2_gnt", 32'(gnt), 32'h4);
      chk("t2_id", 32'(gnt_id), 32'd2);
      chk("t2_en", 32'(bus_en), 32'h1);
      chk("t2_data", 32'(bus_data), 32'h3);
      req = 4'b0000;
      tick();
      chk_idle("t2_turn");
      tick();
      chk_idle("t2_idle");

      // 3: all request after reset -> 0,1,2,3,0 for 8 clks each, one gap between
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req_data = 16'hDCBA; req = 4'b1111;
      tick();
      for (int o = 0; o < 5; o++) begin
         for (int c = 0; c < 8; c++) begin
            chk("t3_gnt", 32'(gnt), 32'(1 << (o % 4)));
            chk("t3_id", 32'(gnt_id), 32'(o % 4));
            chk("t3_data", 32'(bus_data), 32'(4'hA + o % 4));
            tick();
         end
         chk_idle("t3_gap");
         tick();
      end
      chk("t3_next", 32'(gnt), 32'h2);
      req = 4'b0000;
      tick();
      chk_idle("t3_drop");
      tick();

      // 4: X on req[1] is ignored for arbitration, but it sets the sticky x_err
      req = 4'b1000; if (fs) req[1] = 1'bx;
      tick();
      chk("t4_gnt", 32'(gnt), 32'h8);
      chk("t4_id", 32'(gnt_id), 32'd3);
      chk("t4_data", 32'(bus_data), 32'hD);
      chk("t4_xerr_set", 32'(x_err), 32'(fs));
      req[1] = 1'b0;
      tick();
      chk("t4_xerr_sticky", 32'(x_err), 32'(fs));
      x_err_clr = 1'b1; if (fs) req[1] = 1'bx;
      tick();
      chk("t4_set_wins", 32'(x_err), 32'(fs));
      req[1] = 1'b0;
      tick();
      chk("t4_clr", 32'(x_err), 32'h0);
      x_err_clr = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("t4_sole_hold", 32'(gnt), 32'h8);
      end
      req = 4'b0000;
      tick();
      chk_idle("t4_turn");
      tick();

      // 5: X data from the owner passes to the bus unchanged and flags x_err
      req_data = 16'hDCB0; if (fs) req_data[3:0] = 4'bx01x;
      req = 4'b0001;
      tick();
      chk("t5_gnt", 32'(gnt), 32'h1);
      if (fs) chk("t5_data", 32'(bus_data), 32'(4'bx01x));
      chk("t5_xerr_pre", 32'(x_err), 32'h0);
      tick();
      chk("t5_xerr", 32'(x_err), 32'(fs));
      req_data[3:0] = 4'h5; x_err_clr = 1'b1;
      tick();
      chk("t5_xerr_clr", 32'(x_err), 32'h0);
      chk("t5_data_clean", 32'(bus_data), 32'h5);
      x_err_clr = 1'b0;
      req = 4'b0000;
      tick(); tick();

      // 6: async reset during a grant to requester 1, then restart from requester 0
      req = 4'b0010;
      tick();
      chk("t6_gnt", 32'(gnt), 32'h2);
      req = 4'b0011;
      #3 rst_n = 1'b0;
      #1;
      chk_idle("t6_async");
      chk("t6_id", 32'(gnt_id), 32'h0);
      tick();
      chk_idle("t6_held");
      rst_n = 1'b1;
      tick();
      chk("t6_restart_gnt", 32'(gnt), 32'h1);
      chk("t6_restart_id", 32'(gnt_id), 32'h0);
      chk("t6_restart_data", 32'(bus_data), 32'h5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
